seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001: Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002: Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range >= 2.
REQ-003: clk  input  1  single clock, all state on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: en  input  1  display enable; 0 blanks all outputs.
REQ-006: load  input  1  when 1 at a rising edge, captures data_in and dp_in into the shadow register.
REQ-007: data_in  input  4*NUM_DIGITS  hex nibbles; digit k occupies bits [4k+3:4k], digit 0 rightmost.
REQ-008: dp_in  input  NUM_DIGITS  decimal point per digit, bit k for digit k, 1 = lit.
REQ-009: seg_out  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-010: dp_out  output  1  active-low decimal point, registered.
REQ-011: an_out  output  NUM_DIGITS  active-low digit select, one-cold or all ones, registered.
REQ-012: frame_tick  output  1  one-cycle pulse per completed scan frame, registered.

Function
REQ-013: Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; at wrap, digit index idx SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-014: All outputs SHALL be registered from pre-edge state (div_cnt, idx, shadow, en); latency 1 cycle.
REQ-015: Dead time: while div_cnt == 0, an_out SHALL be all ones (anti-ghosting); otherwise an_out SHALL be all ones except bit idx = 0.
REQ-016: seg_out SHALL encode shadow nibble idx as hex 0..F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-017: dp_out SHALL be ~shadow_dp[idx].
REQ-018: frame_tick SHALL be 1 for exactly one cycle, on the edge after the cycle with div_cnt == SCAN_DIV-1 and idx == NUM_DIGITS-1; period NUM_DIGITS*SCAN_DIV cycles.
REQ-019: Shadow register SHALL update only on load; new values SHALL appear on outputs one cycle after the capturing edge, mid-slot if applicable; no tearing within a single output cycle.
REQ-020: en = 0 SHALL force seg_out = 7F, dp_out = 1, an_out = all ones on the next edge; div_cnt, idx, frame_tick SHALL keep running.
REQ-021: en and load in the same cycle SHALL both take effect independently.
REQ-022: With NUM_DIGITS = 1, idx SHALL stay 0 and frame_tick SHALL pulse every SCAN_DIV cycles.

Reset
REQ-023: rst_n = 0 SHALL immediately (asynchronously) set div_cnt = 0, idx = 0, shadow data and dp = 0, seg_out = 7F, dp_out = 1, an_out = all ones, frame_tick = 0.
REQ-024: Reset asserted mid-frame SHALL abandon the frame; after release, the scan SHALL restart at digit 0 with a dead-time cycle first.

Configuration
REQ-025: Macro SEG_LZ_BLANK_EN defined: digit k > 0 SHALL be blanked (seg_out = 7F) when its nibble and all higher nibbles are 0 and its dp bit is 0; digit 0 SHALL never be blanked.
REQ-026: SEG_LZ_BLANK_EN undefined: every digit SHALL display its nibble; no blanking logic SHALL be present.

Verification (NUM_DIGITS = 4, SCAN_DIV = 4)
REQ-027: Reset: rst_n = 0 mid-scan -> seg_out = 7F, dp_out = 1, an_out = 1111, frame_tick = 0 without waiting for a clock edge.
REQ-028: Scan: load data_in = 0x1234, dp_in = 0000 -> an_out = 1111 for 1 cycle, then 1110 with seg_out = 19 for 3 cycles, then 1111, then 1101 with seg_out = 30; frame_tick every 16 cycles.
REQ-029: Decode: load each nibble 0..F on digit 0 -> seg_out matches the REQ-016 table; dp_in = 0001 -> dp_out = 0 only while digit 0 is selected.
REQ-030: Enable: en = 0 mid-slot -> next edge seg_out = 7F, an_out = 1111; frame_tick spacing stays 16; en = 1 resumes at the current idx.
REQ-031: Leading-zero blanking: load 0x0050 -> with SEG_LZ_BLANK_EN, digits 3 and 2 give seg_out = 7F, digit 1 gives 12, digit 0 gives 40; without the macro, digits 3 and 2 give 40.
REQ-032: Load mid-slot: load 0x0008 while digit 0 is displayed -> seg_out changes to 00 one cycle after the capturing edge, and an_out is unchanged.

Source files
------------

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Multiplexed 7-segment scan driver with shadow register and
//            dead-time anti-ghosting. Optional macro: SEG_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF = 7'h7F;

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic                    slot_end;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    blank_sel;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [NUM_DIGITS-1:0]   blank_vec;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and everything above it reads zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blank
        if (k == 0) begin : g_lsd
            assign blank_vec[k] = 1'b0;
        end else begin : g_upper
            assign blank_vec[k] = ~(|shadow_data_q[4*NUM_DIGITS-1:4*k]) & ~shadow_dp_q[k];
        end
    end
`else
    assign blank_vec = '0;
`endif

    assign slot_end = (div_cnt_q == DIV_MAX);

    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        an_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel   = shadow_data_q[4*k +: 4];
                dp_sel    = shadow_dp_q[k];
                blank_sel = blank_vec[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    always_comb begin
        div_cnt_d     = slot_end ? '0 : div_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        shadow_data_d = load ? data_in : shadow_data_q;
        shadow_dp_d   = load ? dp_in   : shadow_dp_q;

        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        an_d   = '1;
        if (en) begin
            seg_d = blank_sel ? SEG_OFF : hex7(nib_sel);
            dp_d  = ~dp_sel;
            // First cycle of every slot keeps all anodes off to avoid ghosting.
            an_d  = (div_cnt_q == '0) ? '1 : an_sel;
        end
        tick_d = slot_end && (idx_q == IDX_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= '1;
            tick_q        <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            tick_q        <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Scoreboard bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] an;
        logic          tick;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            load;
    logic [4*ND-1:0] data_in;
    logic [ND-1:0]   dp_in;
    logic [6:0]      seg_out;
    logic            dp_out;
    logic [ND-1:0]   an_out;
    logic            frame_tick;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    logic [6:0] hex_tab [16];

    int              edge_cnt;
    logic [4*ND-1:0] m_data;
    logic [ND-1:0]   m_dp;

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: the slot timeline is pure arithmetic on the number of edges since reset.
    function automatic exp_t model(input int e, input logic en_v);
        exp_t r;
        int div, idx, nib;
        logic blank;
        div = e % SD;
        idx = (e / SD) % ND;
        nib = int'((m_data >> (4 * idx)) & 16'hF);
        blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
        blank = (idx > 0) && ((m_data >> (4 * idx)) == 0) && !m_dp[idx];
`endif
        r.tick = (div == SD - 1) && (idx == ND - 1);
        if (!en_v) begin
            r.seg = 7'h7F;
            r.dp  = 1'b1;
            r.an  = '1;
        end else begin
            r.seg = blank ? 7'h7F : hex_tab[nib];
            r.dp  = ~m_dp[idx];
            r.an  = (div == 0) ? '1 : ~(ND'(1) << idx);
        end
        return r;
    endfunction

    // Called at a falling edge: drive inputs, predict the next rising edge, advance model.
    task automatic step(input logic en_v, input logic ld, input logic [4*ND-1:0] d, input logic [ND-1:0] p);
        en      = en_v;
        load    = ld;
        data_in = d;
        dp_in   = p;
        exp_q.push_back(model(edge_cnt, en_v));
        if (ld) begin
            m_data = d;
            m_dp   = p;
        end
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_seg",  32'(seg_out),    32'h7F);
        check("rst_dp",   32'(dp_out),     32'h1);
        check("rst_an",   32'(an_out),     32'hF);
        check("rst_tick", 32'(frame_tick), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
        m_data   = '0;
        m_dp     = '0;
    endtask

    // Monitor: every output cycle is compared against the oldest prediction.
    int cyc = 0;
    int last_tick = -1;
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) last_tick = -1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("seg",  32'(seg_out),    32'(x.seg));
                check("dp",   32'(dp_out),     32'(x.dp));
                check("an",   32'(an_out),     32'(x.an));
                check("tick", 32'(frame_tick), 32'(x.tick));
            end
            if (rst_n && frame_tick) begin
                if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(ND * SD));
                last_tick = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        dp_in    = '0;
        edge_cnt = 0;
        m_data   = '0;
        m_dp     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic scan of 0x1234
        step(1'b1, 1'b1, 16'h1234, 4'b0000);
        repeat (40) step(1'b1, 1'b0, 16'(($urandom)), 4'($urandom));

        // Decode sweep on digit 0 with its decimal point lit
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 1'b1, 16'(v), 4'b0001);
            repeat (15) step(1'b1, 1'b0, 16'h0, 4'b0);
        end

        // Leading-zero pattern and a mid-slot load
        step(1'b1, 1'b1, 16'h0050, 4'b0000);
        repeat (20) step(1'b1, 1'b0, 16'h0, 4'b0);
        step(1'b1, 1'b0, 16'h0, 4'b0);
        step(1'b1, 1'b1, 16'h0008, 4'b0000);
        repeat (20) step(1'b1, 1'b0, 16'h0, 4'b0);

        do_reset();

        // Randomised traffic: enable toggles, occasional loads, both at once
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), 4'($urandom));
        end

        // Long disable window keeps the frame timing alive
        repeat (40) step(1'b0, 1'b0, 16'h0, 4'b0);
        repeat (20) step(1'b1, 1'b0, 16'h0, 4'b0);

        do_reset();
        step(1'b1, 1'b1, 16'hA0C0, 4'b0100);
        repeat (64) step(($urandom_range(0, 3) != 0), 1'b0, 16'h0, 4'b0);

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
